// File: rtl/arm_regbank.sv
// rtl/arm_regbank.sv - ARMv4-style register bank: 3 read ports, 1 write port, auto-increment PC, CPSR, banked R13/R14.
// Optional feature macro REGBANK_BYPASS_EN forwards the write data to read ports hitting the written register.
module arm_regbank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int PC_INC   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    input  logic [ADDR_W-1:0] i_rd_addr_c,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    output logic [DATA_W-1:0] o_rd_data_c,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_pc_inc_en,
    output logic [DATA_W-1:0] o_pc_out,
    input  logic              i_flag_we,
    input  logic [3:0]        i_flags_in,
    input  logic              i_mode_we,
    input  logic [4:0]        i_mode_in,
    output logic [31:0]       o_cpsr_out
);

    localparam int NUM_SHARED = NUM_REGS - 3;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LR_IDX = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(NUM_REGS - 3);
    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    logic [DATA_W-1:0] r_shared [NUM_SHARED];
    logic [DATA_W-1:0] r_sp     [3];
    logic [DATA_W-1:0] r_lr     [3];
    logic [DATA_W-1:0] r_pc;
    logic [3:0]        r_flags;
    logic [1:0]        r_if;
    logic [4:0]        r_mode;

    logic [1:0]        w_bank;
    logic              w_wr_valid;
    logic              w_wr_pc;
    logic              w_mode_legal;
    logic [ADDR_W-1:0] w_rd_addr [3];
    logic [DATA_W-1:0] w_rd_data [3];

    // USR and SYS share bank 0; the mode register only ever holds legal modes.
    always_comb begin
        case (r_mode)
            MODE_IRQ: w_bank = 2'd1;
            MODE_SVC: w_bank = 2'd2;
            default:  w_bank = 2'd0;
        endcase
    end

    assign w_mode_legal = (i_mode_in == MODE_USR) || (i_mode_in == MODE_IRQ) ||
                          (i_mode_in == MODE_SVC) || (i_mode_in == MODE_SYS);
    assign w_wr_valid   = i_wr_en && ({{(32-ADDR_W){1'b0}}, i_wr_addr} < 32'(NUM_REGS));
    assign w_wr_pc      = w_wr_valid && (i_wr_addr == PC_IDX);

    assign w_rd_addr[0] = i_rd_addr_a;
    assign w_rd_addr[1] = i_rd_addr_b;
    assign w_rd_addr[2] = i_rd_addr_c;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rd_data[p] = '0;
            if (w_rd_addr[p] == PC_IDX) begin
                w_rd_data[p] = r_pc;
            end else if (w_rd_addr[p] == LR_IDX) begin
                w_rd_data[p] = r_lr[w_bank];
            end else if (w_rd_addr[p] == SP_IDX) begin
                w_rd_data[p] = r_sp[w_bank];
            end else begin
                for (int i = 0; i < NUM_SHARED; i++) begin
                    if (w_rd_addr[p] == ADDR_W'(i)) begin
                        w_rd_data[p] = r_shared[i];
                    end
                end
            end
`ifdef REGBANK_BYPASS_EN
            // Reads and the write both resolve banks with the current mode, so address equality is enough.
            if (w_wr_valid && (i_wr_addr == w_rd_addr[p])) begin
                w_rd_data[p] = i_wr_data;
            end
`endif
        end
    end

    assign o_rd_data_a = w_rd_data[0];
    assign o_rd_data_b = w_rd_data[1];
    assign o_rd_data_c = w_rd_data[2];
    assign o_pc_out    = r_pc;
    assign o_cpsr_out  = {r_flags, 20'd0, r_if, 1'b0, r_mode};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SHARED; i++) begin
                r_shared[i] <= '0;
            end
            for (int b = 0; b < 3; b++) begin
                r_sp[b] <= '0;
                r_lr[b] <= '0;
            end
        end else if (w_wr_valid) begin
            if (i_wr_addr == LR_IDX) begin
                r_lr[w_bank] <= i_wr_data;
            end else if (i_wr_addr == SP_IDX) begin
                r_sp[w_bank] <= i_wr_data;
            end else begin
                for (int i = 0; i < NUM_SHARED; i++) begin
                    if (i_wr_addr == ADDR_W'(i)) begin
                        r_shared[i] <= i_wr_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= '0;
        end else if (w_wr_pc) begin
            r_pc <= i_wr_data;
        end else if (i_pc_inc_en) begin
            r_pc <= r_pc + DATA_W'(PC_INC);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= 4'd0;
            r_if    <= 2'b11;
            r_mode  <= MODE_SVC;
        end else begin
            if (i_flag_we) begin
                r_flags <= i_flags_in;
            end
            if (i_mode_we && w_mode_legal) begin
                r_mode <= i_mode_in;
            end
        end
    end

endmodule

// File: tb/tb_arm_regbank.sv
// tb/tb_arm_regbank.sv - scoreboard testbench for arm_regbank (honours REGBANK_BYPASS_EN).
module tb_arm_regbank;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 5;
`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, rd_addr_c;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_c;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              pc_inc_en;
    logic [DATA_W-1:0] pc_out;
    logic              flag_we;
    logic [3:0]        flags_in;
    logic              mode_we;
    logic [4:0]        mode_in;
    logic [31:0]       cpsr_out;

    arm_regbank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .PC_INC(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b), .i_rd_addr_c(rd_addr_c),
        .o_rd_data_a(rd_data_a), .o_rd_data_b(rd_data_b), .o_rd_data_c(rd_data_c),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_pc_inc_en(pc_inc_en), .o_pc_out(pc_out),
        .i_flag_we(flag_we), .i_flags_in(flags_in),
        .i_mode_we(mode_we), .i_mode_in(mode_in), .o_cpsr_out(cpsr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int s);
        case (s)
            0:       return rd_data_a;
            1:       return rd_data_b;
            2:       return rd_data_c;
            3:       return pc_out;
            default: return cpsr_out;
        endcase
    endfunction

    // Monitor: compares every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                checks++;
                if (get_sig(q[i].sig) !== q[i].val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", q[i].name, get_sig(q[i].sig), q[i].val);
                end
                q.delete(i);
            end else if (q[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: never sampled, expected 0x%08h", q[i].name, q[i].val);
                q.delete(i);
            end
        end
    end

    task automatic push_exp(input int sig, input logic [31:0] val, input string name, input int delay);
        exp_t e;
        e.due = cyc + delay; e.sig = sig; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        wr_en = 1'b0; pc_inc_en = 1'b0; flag_we = 1'b0; mode_we = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
        rd_addr_a = a; rd_addr_b = b; rd_addr_c = c;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc_inc_en = 1'b0;
        flag_we = 1'b0; flags_in = '0; mode_we = 1'b0; mode_in = '0;
        rd(0, 13, 15);
        repeat (2) @(posedge clk);
        #1;
        push_exp(4, 32'h000000D3, "rst_cpsr", 0);
        push_exp(3, 32'h0, "rst_pc", 0);
        push_exp(2, 32'h0, "rst_rd_pc", 0);
        rst_n = 1'b1;

        nxt(); push_exp(0, 0, "post_rst_rd_a", 0); push_exp(1, 0, "post_rst_rd_b", 0);
        push_exp(4, 32'h000000D3, "post_rst_cpsr", 0);

        nxt(); rd(3, 3, 3); wr(3, 32'hDEADBEEF);
        push_exp(0, BYP ? 32'hDEADBEEF : 32'h0, "r3_write_cycle", 0);
        nxt(); push_exp(0, 32'hDEADBEEF, "r3_port_a", 0);
        push_exp(1, 32'hDEADBEEF, "r3_port_b", 0); push_exp(2, 32'hDEADBEEF, "r3_port_c", 0);

        nxt(); wr(20, 32'h77); rd(20, 4, 3);
        nxt(); push_exp(0, 0, "oob_read", 0); push_exp(1, 0, "oob_no_alias", 0);

        nxt(); wr(13, 32'h1111); rd(13, 14, 15);
        nxt(); mode_we = 1'b1; mode_in = 5'b10010;
        push_exp(0, 32'h1111, "svc_r13", 0); push_exp(4, 32'h000000D2, "cpsr_irq", 1);
        nxt(); push_exp(0, 0, "irq_r13_empty", 0);
        wr(13, 32'h2222); mode_we = 1'b1; mode_in = 5'b10011;
        push_exp(0, BYP ? 32'h2222 : 32'h0, "irq_r13_wr_cycle", 0);
        nxt(); push_exp(0, 32'h1111, "svc_r13_back", 0); push_exp(4, 32'h000000D3, "cpsr_svc", 0);
        nxt(); mode_we = 1'b1; mode_in = 5'b10010;
        nxt(); push_exp(0, 32'h2222, "irq_r13_old_bank", 0);
        mode_we = 1'b1; mode_in = 5'b00101; flag_we = 1'b1; flags_in = 4'b0101;
        push_exp(4, 32'h500000D2, "illegal_mode_held", 1);
        nxt(); flag_we = 1'b1; flags_in = 4'b1010; mode_we = 1'b1; mode_in = 5'b10000;
        push_exp(4, 32'hA00000D0, "flags_and_usr", 1);
        nxt(); wr(14, 32'h3333);
        nxt(); push_exp(0, 0, "usr_r13", 0); push_exp(1, 32'h3333, "usr_r14", 0);

        nxt(); wr(15, 32'hFFFFFFFC);
        nxt(); pc_inc_en = 1'b1;
        push_exp(3, 32'hFFFFFFFC, "pc_written", 0); push_exp(2, 32'hFFFFFFFC, "rd_pc_port", 0);
        push_exp(3, 32'h0, "pc_wrap", 1);
        nxt(); pc_inc_en = 1'b1; wr(15, 32'h100);
        push_exp(2, BYP ? 32'h100 : 32'h0, "pc_wr_cycle_read", 0);
        push_exp(3, 32'h100, "pc_wr_wins", 1);
        nxt(); pc_inc_en = 1'b1; push_exp(3, 32'h104, "pc_inc", 1);

        nxt(); rd(7, 8, 15); wr(7, 32'h55);
        push_exp(0, BYP ? 32'h55 : 32'h0, "r7_write_cycle", 0);
        push_exp(1, 0, "r8_unaffected", 0);
        nxt(); push_exp(0, 32'h55, "r7_next_cycle", 0);

        nxt(); rd(9, 3, 15); wr(9, 32'h99);
        #2 rst_n = 1'b0;
        nxt(); rst_n = 1'b1;
        push_exp(0, 0, "rst_mid_r9", 0); push_exp(1, 0, "rst_mid_r3", 0);
        push_exp(3, 0, "rst_mid_pc", 0); push_exp(4, 32'h000000D3, "rst_mid_cpsr", 0);
        nxt(); push_exp(0, 0, "rst_mid_r9_later", 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
